// File: rtl/seg_scan_decoder.sv
// Readback monitor for a multiplexed active-low 7-segment panel; decodes stable digits into a BCD frame.
// Defining SEG_ERR_CNT_EN adds the saturating err_cnt output.
module seg_scan_decoder #(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            Segs,
    input  logic [N_DIGITS-1:0]   An,
    input  logic                  err_clr,
    output logic [4*N_DIGITS-1:0] Digits,
    output logic                  frame_valid,
    output logic                  err
`ifdef SEG_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int         IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int         KEY_W    = N_DIGITS + 7;
    localparam logic [7:0] STABLE_N = 8'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

    state_t                   state, state_d;
    logic [7:0]               cnt, cnt_d;
    logic [6:0]               s_segs;
    logic [N_DIGITS-1:0]      s_an, an_low, seen, seen_d;
    logic [KEY_W-1:0]         key, prev_key;
    logic                     one_hot, multi, multi_q;
    logic                     capture, frame_done, err_evt;
    logic [IDX_W-1:0]         idx;
    logic [3:0]               nibble;
    logic [N_DIGITS-1:0][3:0] shadow, merged;

    function automatic logic [3:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 4'h0;
            7'b1001111: decode = 4'h1;
            7'b0010010: decode = 4'h2;
            7'b0000110: decode = 4'h3;
            7'b1001100: decode = 4'h4;
            7'b0100100: decode = 4'h5;
            7'b0100000: decode = 4'h6;
            7'b0001111: decode = 4'h7;
            7'b0000000: decode = 4'h8;
            7'b0000100: decode = 4'h9;
            7'b1111111: decode = 4'hF;
            default:    decode = 4'hE;
        endcase
    endfunction

    assign key     = {s_an, s_segs};
    assign an_low  = ~s_an;
    assign one_hot = (an_low != '0) && ((an_low & (an_low - N_DIGITS'(1))) == '0);
    assign multi   = (an_low != '0) && !one_hot;
    assign nibble  = decode(s_segs);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (an_low[i]) idx = IDX_W'(i);
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        if (!one_hot) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = TRACK;
                    cnt_d   = 8'd1;
                end
                TRACK: begin
                    if (key != prev_key) begin
                        cnt_d = 8'd1;
                    end else if (cnt >= STABLE_N) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (key != prev_key) begin
                        state_d = TRACK;
                        cnt_d   = 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Multi-anode errors fire only on the first cycle of each illegal strobe episode.
    always_comb begin
        merged      = shadow;
        merged[idx] = nibble;
        seen_d      = seen | (N_DIGITS'(1) << idx);
        frame_done  = capture && (&seen_d);
        err_evt     = (capture && (nibble == 4'hE)) || (multi && !multi_q);
    end

    // NOTE: shadow is reset along with seen so a reset mid-scan cannot leak stale digits into a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_segs      <= '1;
            s_an        <= '1;
            prev_key    <= '1;
            multi_q     <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '1;
            seen        <= '0;
            Digits      <= '1;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            s_segs      <= Segs;
            s_an        <= An;
            prev_key    <= key;
            multi_q     <= multi;
            state       <= state_d;
            cnt         <= cnt_d;
            frame_valid <= frame_done;
            if (capture) begin
                shadow <= merged;
                seen   <= frame_done ? '0 : seen_d;
                if (frame_done) Digits <= merged;
            end
            if (err_evt)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

`ifdef SEG_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= err_evt ? 8'd1 : 8'd0;
        end else if (err_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
